hack_cpu_core: RTL
==================

Name: hack_cpu_core

Overview:
- Hack CPU datapath and control stage sitting directly upstream of the ALU.
- Decodes each 16-bit Hack instruction and drives the ALU's x/y operands and six control bits.
- Consumes the ALU's out/zr/ng to update the A, D and PC registers.
- Generates the data-memory interface (out_m, write_m, address_m).
- An instr_valid qualifier lets instruction ROM/bus wait states stall the core without corrupting state.

Parameters:
- PC_W, 15, width of program counter and data address.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  synchronous active-low reset.
- instruction  in  16  instruction fetched at address pc.
- instr_valid  in  1  1 = instruction is valid this cycle and may execute; 0 = stall.
- in_m  in  16  data-memory read value at address_m (combinational, same cycle).
- out_m  out  16  ALU result, value to write to memory.
- write_m  out  1  memory write strobe for this cycle.
- address_m  out  PC_W  data address, equal to A[PC_W-1:0].
- pc  out  PC_W  address of the instruction to fetch.

Behaviour:
- One clock; reset is synchronous and active-low (reset_n sampled on rising clk edge).
- State registers: A[15:0], D[15:0], PC[PC_W-1:0].
- Reset (reset_n=0 at edge): A=0, D=0, PC=RESET_PC. Reset wins over instr_valid.
- While reset_n=0: write_m=0.
- Reset asserted mid-program discards the in-flight instruction; no memory write is issued that cycle.
- Decode, A-instruction (instruction[15]=0): A <= instruction; D unchanged; write_m=0; PC <= PC+1.
- Decode, C-instruction (instruction[15]=1):
  - bits[14:13] ignored.
  - a = bit12.
  - zx, nx, zy, ny, f, no = bits 11..6.
  - dest A, D, M = bits 5, 4, 3.
  - jump j1, j2, j3 = bits 2, 1, 0.
- ALU hookup: x = D; y = a ? in_m : A. out_m = ALU out at all times, including during A-instructions and stalls (don't-care to memory).
- write_m = reset_n & instr_valid & instruction[15] & bit3. Combinational; memory latches on the same edge.
- address_m = current A register (pre-update) in the same cycle. Writes to M use the old A even when dest also includes A.
- At the edge when a valid C-instruction executes: A <= out if bit5; D <= out if bit4. Both may update together.
- Jump taken = (j1 & ng) | (j2 & zr) | (j3 & ~zr & ~ng).
  - 000: never.
  - 111: always.
  - Flags come from the current ALU result.
- PC update: if taken, PC <= old A[PC_W-1:0] (register value before this edge, even when dest A). Else PC <= PC+1.
- PC increments modulo 2^PC_W: 0x7FFF -> 0x0000.
- Stall (instr_valid=0): A, D and PC hold; write_m=0; pc output unchanged, so the fetch address is re-presented.
- Arithmetic: 16-bit two's complement; the ALU's add wraps silently and there is no overflow flag.

Decomposition:
- Shared package hack_pkg holds:
  - instruction bit-position constants (IS_C=15, A_BIT=12, CTRL_MSB=11, DEST_A=5, DEST_D=4, DEST_M=3, JMP_LSB=0);
  - the jump-code enum (JNULL..JMP);
  - the PC_W default.
- Instantiate the existing ALU module unchanged.
- One small sub-module, hack_jump_unit: inputs j[2:0], zr, ng; output taken. Purely combinational.
- Registers and next-PC logic stay in hack_cpu_core.

Test Plan:
- Reset then load: hold reset_n=0 two cycles; check A=D=0, pc=0, write_m=0. Release; @21 (0x0015) valid -> next cycle address_m=21, pc=1.
- D arithmetic: @5; D=A (0xEC10); @7; D=D+A (0xE090) -> D=12; then M=D (0xE308) -> out_m=12, write_m=1, address_m=7 during that cycle.
- Jump using old A: A=0x0010; execute AM=M+1;JMP with in_m=4 -> write_m=1, address_m=0x0010, out_m=5; after the edge A=5 and pc=0x0010 (old A, not 5).
- Conditional jumps: D=-1, @20, D;JLT -> pc=20. D=0, @30, D;JGT -> pc=prev+1. D=0, @40, D;JEQ -> pc=40.
- Stall: instr_valid=0 for 3 cycles mid-program carrying a M=D encoding -> write_m stays 0; pc, A, D unchanged; execution resumes correctly when valid returns.
- Wrap and mid-run reset: force PC=0x7FFF via @0x7FFF; 0;JMP, then execute one A-instruction -> pc=0x0000. Assert reset_n=0 during a valid M=D -> write_m=0 and all registers zero after the edge.

Source files
------------

// File: rtl/hack_pkg.sv
// hack_pkg
// Shared definitions for the Hack CPU core and its helpers:
//   - bit positions of the fields inside a 16-bit Hack instruction
//   - the 3-bit jump-condition encoding
//   - the default program-counter / data-address width
package hack_pkg;

    localparam int HACK_PC_W = 15;

    // Instruction field positions
    localparam int IS_C     = 15;
    localparam int A_BIT    = 12;
    localparam int CTRL_MSB = 11;
    localparam int DEST_A   = 5;
    localparam int DEST_D   = 4;
    localparam int DEST_M   = 3;
    localparam int JMP_LSB  = 0;

    // Jump conditions, encoded as {j1, j2, j3}
    typedef enum logic [2:0] {
        JNULL = 3'b000,
        JGT   = 3'b001,
        JEQ   = 3'b010,
        JGE   = 3'b011,
        JLT   = 3'b100,
        JNE   = 3'b101,
        JLE   = 3'b110,
        JMP   = 3'b111
    } jump_e;

endpackage

// File: rtl/hack_alu.sv
// hack_alu
// Standard Hack ALU, purely combinational.
// Ports:
//   x, y        16-bit operands
//   zx, nx      zero / negate x
//   zy, ny      zero / negate y
//   f           1 = add, 0 = bitwise and
//   no          negate the result
//   out         16-bit result (add wraps silently)
//   zr, ng      result is zero / result is negative
module hack_alu (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        zx,
    input  logic        nx,
    input  logic        zy,
    input  logic        ny,
    input  logic        f,
    input  logic        no,
    output logic [15:0] out,
    output logic        zr,
    output logic        ng
);

    logic [15:0] x_z;
    logic [15:0] x_n;
    logic [15:0] y_z;
    logic [15:0] y_n;
    logic [15:0] f_out;

    assign x_z   = zx ? 16'h0000 : x;
    assign x_n   = nx ? ~x_z : x_z;
    assign y_z   = zy ? 16'h0000 : y;
    assign y_n   = ny ? ~y_z : y_z;
    assign f_out = f ? (x_n + y_n) : (x_n & y_n);
    assign out   = no ? ~f_out : f_out;
    assign zr    = (out == 16'h0000);
    assign ng    = out[15];

endmodule

// File: rtl/hack_jump_unit.sv
// hack_jump_unit
// Decides whether a C-instruction's jump field is satisfied by the current
// ALU flags.
// Ports:
//   j      jump field {j1, j2, j3}
//   zr     ALU result is zero
//   ng     ALU result is negative
//   taken  1 = load PC from A
module hack_jump_unit
    import hack_pkg::*;
(
    input  logic [2:0] j,
    input  logic       zr,
    input  logic       ng,
    output logic       taken
);

    // Positive means neither zero nor negative; JGE and JLE fold the
    // zero case into the sign test.
    always_comb begin
        taken = 1'b0;
        case (jump_e'(j))
            JNULL:   taken = 1'b0;
            JGT:     taken = ~zr & ~ng;
            JEQ:     taken = zr;
            JGE:     taken = ~ng;
            JLT:     taken = ng;
            JNE:     taken = ~zr;
            JLE:     taken = ng | zr;
            JMP:     taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/hack_cpu_core.sv
// hack_cpu_core
// Hack CPU datapath and control: decodes each instruction, drives the ALU,
// updates the A, D and PC registers and generates the data-memory interface.
// Ports:
//   clk          rising-edge clock
//   reset_n      synchronous active-low reset
//   instruction  instruction fetched at address pc
//   instr_valid  1 = execute this cycle, 0 = stall (all state holds)
//   in_m         data-memory read value at address_m (same cycle)
//   out_m        ALU result, value written to memory
//   write_m      memory write strobe for this cycle
//   address_m    data address, the current A register
//   pc           address of the instruction to fetch
module hack_cpu_core
    import hack_pkg::*;
#(
    parameter int          PC_W     = HACK_PC_W,
    parameter int unsigned RESET_PC = 0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [15:0]     instruction,
    input  logic            instr_valid,
    input  logic [15:0]     in_m,
    output logic [15:0]     out_m,
    output logic            write_m,
    output logic [PC_W-1:0] address_m,
    output logic [PC_W-1:0] pc
);

    logic [15:0]     reg_a;
    logic [15:0]     reg_d;
    logic [PC_W-1:0] reg_pc;

    logic            is_c;
    logic [5:0]      ctrl;
    logic [15:0]     alu_y;
    logic [15:0]     alu_out;
    logic            alu_zr;
    logic            alu_ng;
    logic            cond_met;
    logic            jump_taken;
    logic [PC_W-1:0] pc_next;
    logic            unused_bits;

    // Bits 14:13 of a C-instruction carry no meaning.
    assign unused_bits = ^instruction[14:13];

    assign is_c  = instruction[IS_C];
    assign ctrl  = instruction[CTRL_MSB -: 6];
    assign alu_y = instruction[A_BIT] ? in_m : reg_a;

    hack_alu u_alu (
        .x   (reg_d),
        .y   (alu_y),
        .zx  (ctrl[5]),
        .nx  (ctrl[4]),
        .zy  (ctrl[3]),
        .ny  (ctrl[2]),
        .f   (ctrl[1]),
        .no  (ctrl[0]),
        .out (alu_out),
        .zr  (alu_zr),
        .ng  (alu_ng)
    );

    hack_jump_unit u_jump (
        .j     (instruction[JMP_LSB +: 3]),
        .zr    (alu_zr),
        .ng    (alu_ng),
        .taken (cond_met)
    );

    // A-instructions carry a constant in the jump-field bits, so the jump
    // decision only counts for C-instructions. The jump target is the A
    // value from before this edge, even when the same instruction writes A.
    assign jump_taken = is_c & cond_met;
    assign pc_next    = jump_taken ? reg_a[PC_W-1:0] : reg_pc + PC_W'(1);

    assign out_m     = alu_out;
    assign write_m   = reset_n & instr_valid & is_c & instruction[DEST_M];
    assign address_m = reg_a[PC_W-1:0];
    assign pc        = reg_pc;

    // Reset takes priority over everything; a stalled cycle leaves all
    // three registers untouched so the same fetch address is re-presented.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            reg_a  <= 16'h0000;
            reg_d  <= 16'h0000;
            reg_pc <= PC_W'(RESET_PC);
        end else if (instr_valid) begin
            if (!is_c) begin
                reg_a <= instruction;
            end else begin
                if (instruction[DEST_A]) begin
                    reg_a <= alu_out;
                end
                if (instruction[DEST_D]) begin
                    reg_d <= alu_out;
                end
            end
            reg_pc <= pc_next;
        end
    end

endmodule
